// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder, time-shared by serial_add_ctrl.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             start_ready_q;
    logic             done_valid_q;
    logic             fa_s;
    logic             fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    full_adder_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum register fills from the MSB end so the LSB lands at bit 0 last.
    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            cout_q        <= 1'b0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid && start_ready_q) begin
                        a_sh_q        <= a;
                        b_sh_q        <= b;
                        carry_q       <= cin;
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        state_q       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        cout_q       <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q here is the carry into the MSB.
                        ovf_q        <= carry_q ^ fa_co;
`endif
                        done_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid_q  <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    done_valid_q  <= 1'b0;
                    start_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign done_valid  = done_valid_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start_valid8, start_ready8, done_valid8, done_ready8, cin8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start_valid1, start_ready1, done_valid1, done_ready1, cin1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf1;
`endif

    int checks   = 0;
    int failures = 0;
    int pushed8 = 0, popped8 = 0, pushed1 = 0, popped1 = 0;

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid8),
        .start_ready (start_ready8),
        .a           (a8),
        .b           (b8),
        .cin         (cin8),
        .done_valid  (done_valid8),
        .done_ready  (done_ready8),
        .sum         (sum8),
        .cout        (cout8)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf         (ovf8)
`endif
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid1),
        .start_ready (start_ready1),
        .a           (a1),
        .b           (b1),
        .cin         (cin1),
        .done_valid  (done_valid1),
        .done_ready  (done_ready1),
        .sum         (sum1),
        .cout        (cout1)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf         (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: full-width sum, carry out, and carry-into-MSB based signed overflow.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic [64:0] full;
        logic [64:0] low;
        logic [63:0] m;
        logic        cmsb;
        exp_t        e;
        full = {1'b0, a} + {1'b0, b} + 65'(ci);
        m    = (64'd1 << (w - 1)) - 64'd1;
        low  = {1'b0, a & m} + {1'b0, b & m} + 65'(ci);
        cmsb = low[w-1];
        e.s  = full[63:0] & ((64'd1 << w) - 64'd1);
        e.co = full[w];
        e.ov = cmsb ^ e.co;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("excl8", {63'd0, done_valid8 & start_ready8}, 64'd0);
            chk("excl1", {63'd0, done_valid1 & start_ready1}, 64'd0);
            if (start_valid8 && start_ready8) begin
                q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, cin8));
                pushed8++;
            end
            if (done_valid8 && done_ready8) begin
                if (q8.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb8_dup: got result %0h with no pending op", sum8);
                end else begin
                    e = q8.pop_front();
                    popped8++;
                    chk("sb8_sum", {56'd0, sum8}, e.s);
                    chk("sb8_cout", {63'd0, cout8}, {63'd0, e.co});
`ifdef SERIAL_ADD_OVF_EN
                    chk("sb8_ovf", {63'd0, ovf8}, {63'd0, e.ov});
`endif
                end
            end
            if (start_valid1 && start_ready1) begin
                q1.push_back(model(1, {63'd0, a1}, {63'd0, b1}, cin1));
                pushed1++;
            end
            if (done_valid1 && done_ready1) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb1_dup: got result %0h with no pending op", sum1);
                end else begin
                    e = q1.pop_front();
                    popped1++;
                    chk("sb1_sum", {63'd0, sum1}, e.s);
                    chk("sb1_cout", {63'd0, cout1}, {63'd0, e.co});
`ifdef SERIAL_ADD_OVF_EN
                    chk("sb1_ovf", {63'd0, ovf1}, {63'd0, e.ov});
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        a8 = v.a; b8 = v.b; cin8 = v.cin; start_valid8 = 1'b1;
        chk({tag, "_ready"}, {63'd0, start_ready8}, 64'd1);
        tick();
        start_valid8 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1;
        lat = 0;
        while (!done_valid8 && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_sum"}, {56'd0, sum8}, {56'd0, v.exp_sum});
        chk({tag, "_cout"}, {63'd0, cout8}, {63'd0, v.exp_cout});
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, v.exp_ovf});
`endif
        done_ready8 = 1'b1;
        tick();
        done_ready8 = 1'b0;
        chk({tag, "_idle_dv"}, {63'd0, done_valid8}, 64'd0);
        chk({tag, "_idle_sr"}, {63'd0, start_ready8}, 64'd1);
        chk({tag, "_hold_sum"}, {56'd0, sum8}, {56'd0, v.exp_sum});
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic acc;
        int   n;
        a8 = a; b8 = b; cin8 = ci; start_valid8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = start_ready8;
            tick();
            n++;
        end while (!acc && n < 200);
        start_valid8 = 1'b0;
        if (!acc) chk("send8_timeout", 64'd0, 64'd1);
    endtask

    task automatic send1(input logic a, input logic b, input logic ci);
        logic acc;
        int   n;
        a1 = a; b1 = b; cin1 = ci; start_valid1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = start_ready1;
            tick();
            n++;
        end while (!acc && n < 200);
        start_valid1 = 1'b0;
        if (!acc) chk("send1_timeout", 64'd0, 64'd1);
    endtask

    bit rnd_phase = 1'b0;

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   n;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        start_valid8 = 1'b0; done_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start_valid1 = 1'b0; done_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        chk("rst_sr8", {63'd0, start_ready8}, 64'd1);
        chk("rst_dv8", {63'd0, done_valid8}, 64'd0);
        chk("rst_sum8", {56'd0, sum8}, 64'd0);
        chk("rst_cout8", {63'd0, cout8}, 64'd0);
        chk("rst_sr1", {63'd0, start_ready1}, 64'd1);
        chk("rst_dv1", {63'd0, done_valid1}, 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Backpressure: result must hold and a second request must be refused.
        v = '{8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0};
        a8 = v.a; b8 = v.b; cin8 = v.cin; start_valid8 = 1'b1;
        tick();
        start_valid8 = 1'b0;
        n = 0;
        while (!done_valid8 && n < 100) begin tick(); n++; end
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1; start_valid8 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_dv", {63'd0, done_valid8}, 64'd1);
            chk("bp_sum", {56'd0, sum8}, 64'h77);
            chk("bp_cout", {63'd0, cout8}, 64'd0);
            chk("bp_sr", {63'd0, start_ready8}, 64'd0);
            tick();
        end
        start_valid8 = 1'b0;
        done_ready8 = 1'b1;
        tick();
        done_ready8 = 1'b0;
        chk("bp_release_dv", {63'd0, done_valid8}, 64'd0);
        chk("bp_release_sr", {63'd0, start_ready8}, 64'd1);
        tick();
        tick();
        chk("bp_no_second", {63'd0, done_valid8}, 64'd0);
        chk("bp_q_empty", 64'(q8.size()), 64'd0);

        // Reset mid-RUN, asserted between edges.
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start_valid8 = 1'b1;
        tick();
        start_valid8 = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sr", {63'd0, start_ready8}, 64'd1);
        chk("mid_rst_dv", {63'd0, done_valid8}, 64'd0);
        chk("mid_rst_sum", {56'd0, sum8}, 64'd0);
        chk("mid_rst_cout", {63'd0, cout8}, 64'd0);
        q8.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(tbl[4], "post_rst");

        // Random back-to-back traffic on both instances.
        pushed8 = 0; popped8 = 0; pushed1 = 0; popped1 = 0;
        rnd_phase = 1'b1;
        fork
            begin
                while (rnd_phase) begin
                    done_ready8 = ($urandom_range(0, 2) != 0);
                    done_ready1 = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join_none
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send8(8'($urandom), 8'($urandom), 1'($urandom));
                end
            end
            begin
                for (int r = 0; r < 4; r++) begin
                    for (int i = 0; i < 8; i++) begin
                        logic [2:0] bits;
                        bits = 3'(i);
                        repeat ($urandom_range(0, 2)) tick();
                        send1(bits[2], bits[1], bits[0]);
                    end
                end
            end
        join
        rnd_phase = 1'b0;
        tick();
        done_ready8 = 1'b1;
        done_ready1 = 1'b1;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin tick(); n++; end
        tick();
        chk("rnd_q8_empty", 64'(q8.size()), 64'd0);
        chk("rnd_q1_empty", 64'(q1.size()), 64'd0);
        chk("rnd_pushed8", 64'(pushed8), 64'd2000);
        chk("rnd_popped8", 64'(popped8), 64'd2000);
        chk("rnd_popped1", 64'(popped1), 64'd32);
        chk("rnd_end_dv8", {63'd0, done_valid8}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
